// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the CPU/DMA memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } arb_owner_t;

  // Width of a counter that must hold the value max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational grant select: fixed CPU priority, DMA wins once the CPU run limit is hit.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_CPU_RUN = 4,
  parameter int RUN_W       = 3
) (
  input  logic             cpu_req_i,
  input  logic             dma_req_i,
  input  logic [RUN_W-1:0] run_cnt_i,
  output arb_owner_t       pick_o
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);

  always_comb begin
    pick_o = OWN_NONE;
    if (cpu_req_i && dma_req_i) begin
      pick_o = (run_cnt_i == RUN_MAX) ? OWN_DMA : OWN_CPU;
    end else if (cpu_req_i) begin
      pick_o = OWN_CPU;
    end else if (dma_req_i) begin
      pick_o = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU/DMA) arbiter for a single-ported memory; one access per MEM_LAT+2 cycles.
// Optional per-port grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MEM_LAT     = 1,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re_L,
  output logic        mem_we_L,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  owner
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] cpu_grants,
  output logic [15:0] dma_grants
`endif
);

  localparam int RUN_W = cnt_width(MAX_CPU_RUN);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);

  arb_state_t       state_q;
  arb_owner_t       owner_q;
  arb_owner_t       pick;
  logic [LAT_W-1:0] lat_cnt_q;
  logic [RUN_W-1:0] run_cnt_q;
  logic [RUN_W-1:0] run_cnt_d;
  logic [15:0]      addr_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;
  logic             re_l_q;
  logic             we_l_q;
  logic             cpu_done_q;
  logic             dma_done_q;

  mem_arb_pick #(
    .MAX_CPU_RUN (MAX_CPU_RUN),
    .RUN_W       (RUN_W)
  ) u_pick (
    .cpu_req_i (cpu_req),
    .dma_req_i (dma_req),
    .run_cnt_i (run_cnt_q),
    .pick_o    (pick)
  );

  // Grants are the ready half of the handshake, so they only exist while idle.
  assign cpu_gnt = !reset && (state_q == ARB_IDLE) && (pick == OWN_CPU);
  assign dma_gnt = !reset && (state_q == ARB_IDLE) && (pick == OWN_DMA);

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (run_cnt_q != RUN_MAX) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_NONE;
      lat_cnt_q  <= '0;
      run_cnt_q  <= '0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      rdata_q    <= 16'h0000;
      re_l_q     <= 1'b1;
      we_l_q     <= 1'b1;
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
    end else begin
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (cpu_gnt) begin
            state_q   <= ARB_ACCESS;
            owner_q   <= OWN_CPU;
            lat_cnt_q <= LAT_W'(MEM_LAT - 1);
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            re_l_q    <= cpu_we;
            we_l_q    <= !cpu_we;
            run_cnt_q <= dma_req ? run_cnt_d : '0;
          end else if (dma_gnt) begin
            state_q   <= ARB_ACCESS;
            owner_q   <= OWN_DMA;
            lat_cnt_q <= LAT_W'(MEM_LAT - 1);
            addr_q    <= dma_addr;
            wdata_q   <= dma_wdata;
            re_l_q    <= dma_we;
            we_l_q    <= !dma_we;
            run_cnt_q <= '0;
          end
        end
        ARB_ACCESS: begin
          if (lat_cnt_q == '0) begin
            // Writes keep the previous read value; the port treats it as don't-care.
            if (!re_l_q) begin
              rdata_q <= mem_rdata;
            end
            re_l_q     <= 1'b1;
            we_l_q     <= 1'b1;
            cpu_done_q <= (owner_q == OWN_CPU);
            dma_done_q <= (owner_q == OWN_DMA);
            state_q    <= ARB_DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        ARB_DONE: begin
          state_q <= ARB_IDLE;
          owner_q <= OWN_NONE;
        end
        default: begin
          state_q <= ARB_IDLE;
          owner_q <= OWN_NONE;
          re_l_q  <= 1'b1;
          we_l_q  <= 1'b1;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re_L  = re_l_q;
  assign mem_we_L  = we_l_q;
  assign cpu_done  = cpu_done_q;
  assign dma_done  = dma_done_q;
  assign cpu_rdata = rdata_q;
  assign dma_rdata = rdata_q;
  assign owner     = owner_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] cpu_grants_q;
  logic [15:0] dma_grants_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_grants_q <= 16'h0000;
      dma_grants_q <= 16'h0000;
    end else begin
      if (cpu_gnt) cpu_grants_q <= cpu_grants_q + 16'd1;
      if (dma_gnt) dma_grants_q <= dma_grants_q + 16'd1;
    end
  end

  assign cpu_grants = cpu_grants_q;
  assign dma_grants = dma_grants_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: MEM_LAT=1 instance (table + scoreboard) and MEM_LAT=3 instance (corner sequences).
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 1: MEM_LAT=1
  logic        rst1;
  logic        c1_req, c1_we, c1_gnt, c1_done;
  logic [15:0] c1_addr, c1_wdata, c1_rdata;
  logic        d1_req, d1_we, d1_gnt, d1_done;
  logic [15:0] d1_addr, d1_wdata, d1_rdata;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_re_L, m1_we_L;
  logic [1:0]  own1;
  // Instance 3: MEM_LAT=3
  logic        rst3;
  logic        c3_req, c3_we, c3_gnt, c3_done;
  logic [15:0] c3_addr, c3_wdata, c3_rdata;
  logic        d3_req, d3_we, d3_gnt, d3_done;
  logic [15:0] d3_addr, d3_wdata, d3_rdata;
  logic [15:0] m3_addr, m3_wdata, m3_rdata;
  logic        m3_re_L, m3_we_L;
  logic [1:0]  own3;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] cg1, dg1, cg3, dg3;
`endif

  mem_bus_arbiter #(.MEM_LAT(1), .MAX_CPU_RUN(4)) u_dut1 (
    .clock(clock), .reset(rst1),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_gnt(c1_gnt), .cpu_done(c1_done), .cpu_rdata(c1_rdata),
    .dma_req(d1_req), .dma_we(d1_we), .dma_addr(d1_addr), .dma_wdata(d1_wdata),
    .dma_gnt(d1_gnt), .dma_done(d1_done), .dma_rdata(d1_rdata),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_re_L(m1_re_L), .mem_we_L(m1_we_L),
    .mem_rdata(m1_rdata), .owner(own1)
`ifdef MEM_ARB_STATS_EN
    , .cpu_grants(cg1), .dma_grants(dg1)
`endif
  );

  mem_bus_arbiter #(.MEM_LAT(3), .MAX_CPU_RUN(4)) u_dut3 (
    .clock(clock), .reset(rst3),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_gnt(c3_gnt), .cpu_done(c3_done), .cpu_rdata(c3_rdata),
    .dma_req(d3_req), .dma_we(d3_we), .dma_addr(d3_addr), .dma_wdata(d3_wdata),
    .dma_gnt(d3_gnt), .dma_done(d3_done), .dma_rdata(d3_rdata),
    .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_re_L(m3_re_L), .mem_we_L(m3_we_L),
    .mem_rdata(m3_rdata), .owner(own3)
`ifdef MEM_ARB_STATS_EN
    , .cpu_grants(cg3), .dma_grants(dg3)
`endif
  );

  // Memory model for instance 1 (256 words, address aliased on low byte); instance 3 returns ~addr.
  logic [15:0] mem1 [256];
  always @(posedge clock) begin
    if (rst1) mem1[8'h40] <= 16'hBEEF;
    else if (!m1_we_L) mem1[m1_addr[7:0]] <= m1_wdata;
  end
  assign m1_rdata = mem1[m1_addr[7:0]];
  assign m3_rdata = ~m3_addr;

  typedef struct {
    logic        port;   // 0 = CPU, 1 = DMA
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] rdata;
  } exp_t;

  vec_t vt [8];
  exp_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer and grant-exclusivity monitor.
  always @(negedge clock) begin
    exp_t e;
    if (!rst1) begin
      chk("gnt1_exclusive", {31'd0, c1_gnt & d1_gnt}, 0);
      if (c1_done || d1_done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_spurious_done: cpu_done=%b dma_done=%b with no access outstanding", c1_done, d1_done);
        end else begin
          e = sb.pop_front();
          chk("sb_done_port", {31'd0, d1_done}, {31'd0, e.port});
          chk("sb_single_done", {31'd0, c1_done & d1_done}, 0);
          if (!e.we) chk("sb_rdata", e.port ? d1_rdata : c1_rdata, e.rdata);
        end
      end
    end
    if (!rst3) chk("gnt3_exclusive", {31'd0, c3_gnt & d3_gnt}, 0);
  end

  task automatic run_vec1(input vec_t v);
    exp_t e;
    int got;
    @(posedge clock); #1;
    if (v.port == 1'b0) begin
      c1_req = 1'b1; c1_we = v.we; c1_addr = v.addr; c1_wdata = v.wdata;
    end else begin
      d1_req = 1'b1; d1_we = v.we; d1_addr = v.addr; d1_wdata = v.wdata;
    end
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clock);
      if ((v.port == 1'b0 && c1_gnt) || (v.port == 1'b1 && d1_gnt)) got = 1;
    end
    chk("v_gnt_seen", got, 1);
    if (got != 0) begin
      e.port = v.port; e.we = v.we; e.rdata = v.exp;
      sb.push_back(e);
      chk("v_gnt_other", {31'd0, v.port ? c1_gnt : d1_gnt}, 0);
      @(posedge clock); #1;
      c1_req = 1'b0; d1_req = 1'b0;
      @(negedge clock);
      chk("v_re_L", {31'd0, m1_re_L}, {31'd0, v.we});
      chk("v_we_L", {31'd0, m1_we_L}, {31'd0, !v.we});
      chk("v_mem_addr", m1_addr, v.addr);
      if (v.we) chk("v_mem_wdata", m1_wdata, v.wdata);
      chk("v_gnt_busy", {30'd0, c1_gnt, d1_gnt}, 0);
      chk("v_owner", own1, v.port ? OWN_DMA : OWN_CPU);
      @(negedge clock);
      chk("v_done", {30'd0, c1_done, d1_done}, v.port ? 2'b01 : 2'b10);
      chk("v_strobes_idle", {30'd0, m1_re_L, m1_we_L}, 2'b11);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic order [10];
    vt[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
    vt[1] = '{1'b1, 1'b1, 16'h8000, 16'h1234, 16'h0000};
    vt[2] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h1234};
    vt[3] = '{1'b0, 1'b1, 16'h0011, 16'hCAFE, 16'h0000};
    vt[4] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'hCAFE};
    vt[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
    vt[6] = '{1'b1, 1'b1, 16'h00FF, 16'h0F0F, 16'h0000};
    vt[7] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h0F0F};

    rst1 = 1'b1; rst3 = 1'b1;
    {c1_req, c1_we, d1_req, d1_we, c3_req, c3_we, d3_req, d3_we} = '0;
    c1_addr = 16'h0; c1_wdata = 16'h0; d1_addr = 16'h0; d1_wdata = 16'h0;
    c3_addr = 16'h0; c3_wdata = 16'h0; d3_addr = 16'h0; d3_wdata = 16'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_owner", own1, OWN_NONE);
    chk("rst_strobes", {30'd0, m1_re_L, m1_we_L}, 2'b11);
    chk("rst_gnt_done", {28'd0, c1_gnt, d1_gnt, c1_done, d1_done}, 0);
    chk("rst_mem_addr", m1_addr, 16'h0000);
    chk("rst_mem_wdata", m1_wdata, 16'h0000);
    chk("rst_rdata", {c1_rdata, d1_rdata}, 32'h0);
    @(posedge clock); #1;
    rst1 = 1'b0; rst3 = 1'b0;

    // Table of single accesses on the MEM_LAT=1 instance.
    for (int i = 0; i < 8; i++) run_vec1(vt[i]);
    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
`ifdef MEM_ARB_STATS_EN
    chk("stats1_cpu", cg1, 16'd4);
    chk("stats1_dma", dg1, 16'd4);
`endif

    // MEM_LAT=3 CPU read with DMA waiting: no grants while busy.
    @(posedge clock); #1;
    c3_req = 1'b1; c3_we = 1'b0; c3_addr = 16'h1230;
    d3_req = 1'b1; d3_we = 1'b0; d3_addr = 16'h0777;
    @(negedge clock);
    chk("t4_cpu_gnt", {31'd0, c3_gnt}, 1);
    chk("t4_dma_gnt", {31'd0, d3_gnt}, 0);
    @(posedge clock); #1;
    c3_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk("t4_gnt_busy", {30'd0, c3_gnt, d3_gnt}, 0);
      chk("t4_re_L", {31'd0, m3_re_L}, (k == 4) ? 1 : 0);
      chk("t4_cpu_done", {31'd0, c3_done}, (k == 4) ? 1 : 0);
      chk("t4_dma_done", {31'd0, d3_done}, 0);
      if (k == 1) chk("t4_owner", own3, OWN_CPU);
      if (k == 4) chk("t4_rdata", c3_rdata, 16'hEDCF);
    end
    @(negedge clock);
    chk("t4_dma_gnt_after", {31'd0, d3_gnt}, 1);
    @(posedge clock); #1;
    d3_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 4) begin
        chk("t4_dma_done_end", {30'd0, c3_done, d3_done}, 2'b01);
        chk("t4_dma_rdata", d3_rdata, 16'hF888);
      end
    end

    // Reset during the 2nd access cycle of a MEM_LAT=3 write; CPU grant with DMA pending bumps run_cnt first.
    @(posedge clock); #1;
    c3_req = 1'b1; c3_we = 1'b1; c3_addr = 16'h2222; c3_wdata = 16'h5555; d3_req = 1'b1;
    @(negedge clock);
    chk("t5_cpu_gnt", {31'd0, c3_gnt}, 1);
    @(posedge clock); #1;
    c3_req = 1'b0; d3_req = 1'b0;
    @(negedge clock);
    chk("t5_we_L_acc1", {31'd0, m3_we_L}, 0);
    @(posedge clock); #1;
    rst3 = 1'b1;
    @(negedge clock);
    chk("t5_we_L_acc2", {31'd0, m3_we_L}, 0);
    @(posedge clock); #1;
    rst3 = 1'b0;
    @(negedge clock);
    chk("t5_strobes", {30'd0, m3_re_L, m3_we_L}, 2'b11);
    chk("t5_owner", own3, OWN_NONE);
    for (int k = 0; k < 4; k++) begin
      chk("t5_no_done", {30'd0, c3_done, d3_done}, 0);
      @(negedge clock);
    end

    // Both requesters held: order C,C,C,C,D,C,C,C,C,D (also shows run_cnt restarted from 0 after reset).
    @(posedge clock); #1;
    c3_req = 1'b1; c3_we = 1'b0; c3_addr = 16'h0100;
    d3_req = 1'b1; d3_we = 1'b0; d3_addr = 16'h0200;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
      @(negedge clock);
      if (c3_gnt || d3_gnt) begin
        order[n] = d3_gnt;
        n++;
      end
    end
    @(posedge clock); #1;
    c3_req = 1'b0; d3_req = 1'b0;
    chk("t3_grant_count", n, 10);
    for (int i = 0; i < n; i++) chk($sformatf("t3_order_%0d", i), {31'd0, order[i]}, (i == 4 || i == 9) ? 1 : 0);
    repeat (6) @(negedge clock);
`ifdef MEM_ARB_STATS_EN
    chk("stats3_cpu", cg3, 16'd8);
    chk("stats3_dma", dg3, 16'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
